// File: rtl/addsub_pkg.sv
// Shared op codes, FSM state encoding and default width for the add/sub accumulator.
package addsub_pkg;

    localparam int unsigned ADDSUB_WIDTH = 8;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/addsub_core.sv
// WIDTH-generic combinational add/sub; carry_out reports borrow when sub=1.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic             carry_raw;

    // Subtraction is a + ~b + 1; overflow when effective operand signs match but result sign differs.
    assign b_eff              = sub ? ~b : b;
    assign {carry_raw, sum}   = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);
    assign carry_out          = sub ? ~carry_raw : carry_raw;
    assign ovf                = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_accumulator.sv
// Handshaked accumulator around addsub_core. Define ADDSUB_ACC_SAT_EN to saturate
// ADD/SUB results on signed overflow instead of wrapping.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] core_sum;
    logic             core_carry;
    logic             core_ovf;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a         (acc_q),
        .b         (data_q),
        .sub       (op_q == OP_SUB),
        .sum       (core_sum),
        .carry_out (core_carry),
        .ovf       (core_ovf)
    );

    // Result selection for the latched op.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op_q)
            OP_LOAD: res = data_q;
            OP_ADD, OP_SUB: begin
                res   = core_sum;
                res_c = core_carry;
                res_v = core_ovf;
`ifdef ADDSUB_ACC_SAT_EN
                // On overflow the true result carries the accumulator's sign.
                if (core_ovf) begin
                    res = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        valid_d  = valid_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = in_op;
                    data_d  = in_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                acc_d   = res;
                carry_d = res_c;
                ovf_d   = res_v;
                zero_d  = (res == '0);
                neg_d   = res[WIDTH-1];
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (in_valid) begin
                        op_d    = in_op;
                        data_d  = in_data;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_acc   = acc_q;
    assign out_carry = carry_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign out_neg   = neg_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed self-checking bench for addsub_accumulator; expectations follow ADDSUB_ACC_SAT_EN.
module tb_addsub_accumulator;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_acc;
    logic       out_carry;
    logic       out_ovf;
    logic       out_zero;
    logic       out_neg;

    int n_checks;
    int n_fail;

    addsub_accumulator #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; issues one op and checks latency, value and flags {C,V,Z,N}.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] data,
                          input logic [7:0] exp_acc, input logic [3:0] exp_flags);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_exec_vld"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_acc"}, 32'(out_acc), 32'(exp_acc));
        check_eq({tag, "_flags"}, 32'({out_carry, out_ovf, out_zero, out_neg}), 32'(exp_flags));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_acc", 32'(out_acc), 32'h00);
        check_eq("rst_flags", 32'({out_carry, out_ovf, out_zero, out_neg}), 32'b0010);
        check_eq("rst_vld", 32'(out_valid), 32'd0);
        check_eq("rst_rdy", 32'(in_ready), 32'd1);

        run_op("ld05",  2'b00, 8'h05, 8'h05, 4'b0000);
        run_op("add03", 2'b01, 8'h03, 8'h08, 4'b0000);
        run_op("sub0a", 2'b10, 8'h0A, 8'hFE, 4'b1001);
        run_op("ldff",  2'b00, 8'hFF, 8'hFF, 4'b0001);
        run_op("add01", 2'b01, 8'h01, 8'h00, 4'b1010);
        run_op("ld7f",  2'b00, 8'h7F, 8'h7F, 4'b0000);
`ifdef ADDSUB_ACC_SAT_EN
        run_op("ovfadd", 2'b01, 8'h01, 8'h7F, 4'b0100);
`else
        run_op("ovfadd", 2'b01, 8'h01, 8'h80, 4'b0101);
`endif
        run_op("ld80",  2'b00, 8'h80, 8'h80, 4'b0001);
`ifdef ADDSUB_ACC_SAT_EN
        run_op("ovfsub", 2'b10, 8'h01, 8'h80, 4'b0101);
`else
        run_op("ovfsub", 2'b10, 8'h01, 8'h7F, 4'b0100);
`endif
        run_op("clr",   2'b11, 8'h5A, 8'h00, 4'b0010);

        // Backpressure: HOLD with out_ready low must ignore a pending request.
        run_op("ld33",  2'b00, 8'h33, 8'h33, 4'b0000);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'b01;
        in_data   = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_acc", 32'(out_acc), 32'h33);
            check_eq("bp_vld", 32'(out_valid), 32'd1);
            check_eq("bp_rdy", 32'(in_ready), 32'd0);
            check_eq("bp_flags", 32'({out_carry, out_ovf, out_zero, out_neg}), 32'b0000);
        end
        out_ready = 1'b1;
        #1 check_eq("bp_rdy_rel", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_exec_vld", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b_vld", 32'(out_valid), 32'd1);
        check_eq("b2b_acc", 32'(out_acc), 32'h34);

        // Reset during EXEC discards the in-flight ADD.
        run_op("ld20", 2'b00, 8'h20, 8'h20, 4'b0000);
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_data  = 8'h10;
        @(posedge clk);
        #1 begin
            in_valid = 1'b0;
            reset    = 1'b1;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("mrst_acc", 32'(out_acc), 32'h00);
        check_eq("mrst_flags", 32'({out_carry, out_ovf, out_zero, out_neg}), 32'b0010);
        check_eq("mrst_vld", 32'(out_valid), 32'd0);
        check_eq("mrst_rdy", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("mrst_late_vld", 32'(out_valid), 32'd0);
        check_eq("mrst_late_acc", 32'(out_acc), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
